// File: rtl/control_sequencer_if.sv
// ============================================================================
// Module : control_sequencer_if
// Brief  : Strobe/status bundle between the hardwired control unit and the datapath.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface control_sequencer_if;
   logic [31:0] IR;
   logic        CON_FF;
   logic        Stop;

   logic        PCout, Zhighout, Zlowout, MDRout, InPortout, Cout, BAout, Rout;
   logic        MARin, Zin, PCin, MDRin, IRin, Yin, OutPortin, Rin, CONin;
   logic        Gra, Grb, Grc;
   logic        IncPC, Read, Write;
   logic [4:0]  ALU_op;
   logic        Run;

   modport master (
      input  IR, CON_FF, Stop,
      output PCout, Zhighout, Zlowout, MDRout, InPortout, Cout, BAout, Rout,
      output MARin, Zin, PCin, MDRin, IRin, Yin, OutPortin, Rin, CONin,
      output Gra, Grb, Grc, IncPC, Read, Write, ALU_op, Run
   );

   modport slave (
      output IR, CON_FF, Stop,
      input  PCout, Zhighout, Zlowout, MDRout, InPortout, Cout, BAout, Rout,
      input  MARin, Zin, PCin, MDRin, IRin, Yin, OutPortin, Rin, CONin,
      input  Gra, Grb, Grc, IncPC, Read, Write, ALU_op, Run
   );
endinterface

`default_nettype wire

// File: rtl/control_sequencer.sv
// ============================================================================
// Module : control_sequencer
// Brief  : Hardwired Moore control unit: fetch T0-T2, per-opcode execute T3-T7.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module control_sequencer #(
   parameter int             OPW     = 5,
   parameter logic [OPW-1:0] ALU_ADD = 5'b00011
) (
   input  wire logic           Clock,
   input  wire logic           Clear,
   control_sequencer_if.master bus
);

   typedef enum logic [3:0] {
      S_RST   = 4'd0,
      S_T0    = 4'd1,
      S_T1    = 4'd2,
      S_T2    = 4'd3,
      S_T3    = 4'd4,
      S_T4    = 4'd5,
      S_T5    = 4'd6,
      S_T6    = 4'd7,
      S_T7    = 4'd8,
      S_PAUSE = 4'd9,
      S_HALT  = 4'd10
   } state_t;

   typedef struct packed {
      logic pc_out, zhigh_out, zlow_out, mdr_out, inport_out, c_out, ba_out, r_out;
      logic mar_in, z_in, pc_in, mdr_in, ir_in, y_in, outport_in, r_in, con_in;
      logic gra, grb, grc;
      logic inc_pc, read, write;
      logic [OPW-1:0] alu_op;
      logic run;
   } ctrl_t;

   localparam logic [OPW-1:0] OP_LD   = 5'b00000;
   localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
   localparam logic [OPW-1:0] OP_ST   = 5'b00010;
   localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
   localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
   localparam logic [OPW-1:0] OP_AND  = 5'b01001;
   localparam logic [OPW-1:0] OP_OR   = 5'b01010;
   localparam logic [OPW-1:0] OP_ADDI = 5'b01011;
   localparam logic [OPW-1:0] OP_BR   = 5'b10010;
   localparam logic [OPW-1:0] OP_JR   = 5'b10011;
   localparam logic [OPW-1:0] OP_JAL  = 5'b10100;
   localparam logic [OPW-1:0] OP_IN   = 5'b10101;
   localparam logic [OPW-1:0] OP_OUT  = 5'b10110;
   localparam logic [OPW-1:0] OP_HALT = 5'b11010;

   state_t         state_q, state_d;
   ctrl_t          ctrl_q, ctrl_d;
   logic [OPW-1:0] opcode;
   logic           unused_ir;

   assign opcode    = bus.IR[31:32-OPW];
   assign unused_ir = ^bus.IR[31-OPW:0];

   // Final execute step per opcode; S_T2 marks opcodes with no execute phase (nop/undefined).
   function automatic state_t last_step(input logic [OPW-1:0] op);
      state_t s;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LDI: s = S_T5;
         OP_LD, OP_ST:                                   s = S_T7;
         OP_BR:                                          s = S_T6;
         OP_JAL:                                         s = S_T4;
         OP_JR, OP_IN, OP_OUT:                           s = S_T3;
         default:                                        s = S_T2;
      endcase
      return s;
   endfunction

   function automatic ctrl_t decode(input state_t s, input logic [OPW-1:0] op, input logic con);
      ctrl_t c;
      c     = '0;
      c.run = (s != S_RST) && (s != S_HALT);
      case (s)
         S_T0: begin
            c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.z_in = 1'b1; c.alu_op = ALU_ADD;
         end
         S_T1: begin
            c.zlow_out = 1'b1; c.pc_in = 1'b1; c.read = 1'b1; c.mdr_in = 1'b1;
         end
         S_T2: begin
            c.mdr_out = 1'b1; c.ir_in = 1'b1;
         end
         S_T3: begin
            case (op)
               OP_ADD, OP_SUB, OP_AND, OP_OR: begin c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
               OP_ADDI, OP_LDI, OP_LD, OP_ST: begin c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1; end
               OP_BR:  begin c.gra = 1'b1; c.r_out = 1'b1; c.con_in = 1'b1; end
               OP_JR:  begin c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1; end
               OP_JAL: begin c.pc_out = 1'b1; c.grb = 1'b1; c.r_in = 1'b1; end
               OP_IN:  begin c.inport_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
               OP_OUT: begin c.gra = 1'b1; c.r_out = 1'b1; c.outport_in = 1'b1; end
               default: ;
            endcase
         end
         S_T4: begin
            case (op)
               OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                  c.grc = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1; c.alu_op = op;
               end
               OP_ADDI, OP_LDI, OP_LD, OP_ST: begin
                  c.c_out = 1'b1; c.z_in = 1'b1; c.alu_op = ALU_ADD;
               end
               OP_BR:  begin c.pc_out = 1'b1; c.y_in = 1'b1; end
               OP_JAL: begin c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1; end
               default: ;
            endcase
         end
         S_T5: begin
            case (op)
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LDI: begin
                  c.zlow_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
               end
               OP_LD, OP_ST: begin c.zlow_out = 1'b1; c.mar_in = 1'b1; end
               OP_BR:        begin c.c_out = 1'b1; c.z_in = 1'b1; c.alu_op = ALU_ADD; end
               default: ;
            endcase
         end
         S_T6: begin
            case (op)
               OP_LD: begin c.read = 1'b1; c.mdr_in = 1'b1; end
               OP_ST: begin c.gra = 1'b1; c.r_out = 1'b1; c.mdr_in = 1'b1; end
               OP_BR: begin c.zlow_out = con; c.pc_in = con; end
               default: ;
            endcase
         end
         S_T7: begin
            case (op)
               OP_LD: begin c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
               OP_ST: c.write = 1'b1;
               default: ;
            endcase
         end
         default: ;
      endcase
      return c;
   endfunction

   // Outputs are decoded from the next state and registered, so they change only with the state.
   // CON_FF is loaded by CONin in T3 of br, so its value during T5 is the one seen in T6.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RST:   state_d = S_T0;
         S_T0:    state_d = S_T1;
         S_T1:    state_d = S_T2;
         S_T2: begin
            if (opcode == OP_HALT)
               state_d = S_HALT;
            else if (last_step(opcode) == S_T2)
               state_d = S_T0;
            else
               state_d = S_T3;
         end
         S_T3, S_T4, S_T5, S_T6, S_T7: begin
            if (state_q == last_step(opcode))
               state_d = S_T0;
            else
               state_d = state_t'(state_q + 4'd1);
         end
         S_PAUSE: if (!bus.Stop) state_d = S_T0;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_RST;
      endcase
      if (state_d == S_T0 && bus.Stop)
         state_d = S_PAUSE;
      ctrl_d = decode(state_d, opcode, bus.CON_FF);
   end

   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         state_q <= S_RST;
         ctrl_q  <= '0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
      end
   end

   assign bus.PCout     = ctrl_q.pc_out;
   assign bus.Zhighout  = ctrl_q.zhigh_out;
   assign bus.Zlowout   = ctrl_q.zlow_out;
   assign bus.MDRout    = ctrl_q.mdr_out;
   assign bus.InPortout = ctrl_q.inport_out;
   assign bus.Cout      = ctrl_q.c_out;
   assign bus.BAout     = ctrl_q.ba_out;
   assign bus.Rout      = ctrl_q.r_out;
   assign bus.MARin     = ctrl_q.mar_in;
   assign bus.Zin       = ctrl_q.z_in;
   assign bus.PCin      = ctrl_q.pc_in;
   assign bus.MDRin     = ctrl_q.mdr_in;
   assign bus.IRin      = ctrl_q.ir_in;
   assign bus.Yin       = ctrl_q.y_in;
   assign bus.OutPortin = ctrl_q.outport_in;
   assign bus.Rin       = ctrl_q.r_in;
   assign bus.CONin     = ctrl_q.con_in;
   assign bus.Gra       = ctrl_q.gra;
   assign bus.Grb       = ctrl_q.grb;
   assign bus.Grc       = ctrl_q.grc;
   assign bus.IncPC     = ctrl_q.inc_pc;
   assign bus.Read      = ctrl_q.read;
   assign bus.Write     = ctrl_q.write;
   assign bus.ALU_op    = ctrl_q.alu_op;
   assign bus.Run       = ctrl_q.run;

endmodule

`default_nettype wire
